// File: rtl/alu_operand_sequencer_pkg.sv
// Shared encodings for the ALU operand sequencer: FSM state codes and the
// function codes understood by the attached 4-bit ALU.
package alu_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT_B  = 2'b01,
    S_EXEC    = 2'b10,
    S_CAPTURE = 2'b11
  } state_t;

  localparam logic [2:0] FN_ADD_FA  = 3'b000;
  localparam logic [2:0] FN_ADD     = 3'b001;
  localparam logic [2:0] FN_SEXT_B  = 3'b010;
  localparam logic [2:0] FN_OR_RED  = 3'b011;
  localparam logic [2:0] FN_AND_RED = 3'b100;
  localparam logic [2:0] FN_CONCAT  = 3'b101;

endpackage

// File: rtl/alu_operand_sequencer_go_edge_sync.sv
// Synchronizes the asynchronous Go push-button level and emits a single-cycle
// pulse on each synchronized rising edge.
module go_edge_sync #(
  parameter int GO_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  output logic go_pulse
);

  logic [GO_SYNC_STAGES-1:0] sync_q;
  logic                      go_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      go_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[GO_SYNC_STAGES-2:0], go};
      go_prev_q <= sync_q[GO_SYNC_STAGES-1];
    end
  end

  // A held button keeps sync and prev equal, so only the first cycle pulses.
  assign go_pulse = sync_q[GO_SYNC_STAGES-1] & ~go_prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A and B serially from one data bus on Go presses, holds them with the
// function code for the external ALU, and registers the ALU output into Result.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DATA_W         = 4,
  parameter int RES_W          = 8,
  parameter int FUNC_W         = 3,
  parameter int GO_SYNC_STAGES = 2
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] Data,
  input  logic [FUNC_W-1:0] Func,
  input  logic              Acc,
  input  logic              Go,
  input  logic [RES_W-1:0]  ALUout,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [FUNC_W-1:0] Function,
  output logic [RES_W-1:0]  Result,
  output logic              Valid,
  output logic              Busy,
  output logic [1:0]        State
);

  state_t state_q, state_d;
  logic   go_pulse;
  logic   load_a, load_b_data, load_b_acc, capture;
  logic   vld_p1;

  go_edge_sync #(
    .GO_SYNC_STAGES(GO_SYNC_STAGES)
  ) u_go_sync (
    .clk     (Clock),
    .rst_n   (Reset_b),
    .go      (Go),
    .go_pulse(go_pulse)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Presses arriving in EXEC or CAPTURE fall through the case and are dropped.
  always_comb begin
    state_d     = state_q;
    load_a      = 1'b0;
    load_b_data = 1'b0;
    load_b_acc  = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_pulse) begin
          load_a = 1'b1;
          if (Acc) begin
            load_b_acc = 1'b1;
            state_d    = S_EXEC;
          end else begin
            state_d    = S_WAIT_B;
          end
        end
      end
      S_WAIT_B: begin
        if (go_pulse) begin
          load_b_data = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Capture stage: Result and its Valid pulse appear together one edge after CAPTURE.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      A        <= '0;
      B        <= '0;
      Function <= '0;
      Result   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (load_a) begin
        A        <= Data;
        Function <= Func;
      end
      if (load_b_data)     B <= Data;
      else if (load_b_acc) B <= Result[DATA_W-1:0];
      if (capture) Result <= ALUout;
      vld_p1 <= capture;
    end
  end

  assign Valid = vld_p1;
  assign Busy  = (state_q != S_IDLE);
  assign State = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: sequencer plus a behavioural model of the part3 ALU.
module tb_alu_operand_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b1;
  logic [3:0] Data = '0;
  logic [2:0] Func = '0;
  logic       Acc = 1'b0;
  logic       Go = 1'b0;
  logic [7:0] ALUout;
  logic [3:0] A, B;
  logic [2:0] Function;
  logic [7:0] Result;
  logic       Valid, Busy;
  logic [1:0] State;

  int tests = 0;
  int fails = 0;

  int vld_cnt = 0;
  int cyc = 0;
  int exec_cyc = 0;
  int vld_cyc = 0;
  logic [7:0] res_at_vld = '0;
  logic saw_wait_b = 1'b0;
  logic [1:0] prev_state = 2'b00;

  always #5 Clock = ~Clock;

  alu_operand_sequencer #(
    .DATA_W(4), .RES_W(8), .FUNC_W(3), .GO_SYNC_STAGES(2)
  ) dut (
    .Clock(Clock), .Reset_b(Reset_b), .Data(Data), .Func(Func), .Acc(Acc),
    .Go(Go), .ALUout(ALUout), .A(A), .B(B), .Function(Function),
    .Result(Result), .Valid(Valid), .Busy(Busy), .State(State)
  );

  // part3 ALU reference behaviour
  always_comb begin
    ALUout = 8'h00;
    case (Function)
      3'b000: ALUout = {4'b0000, 4'b0000} + {4'b0000, A} + {4'b0000, B};
      3'b001: ALUout = {4'b0000, A} + {4'b0000, B};
      3'b010: ALUout = {{4{B[3]}}, B};
      3'b011: ALUout = (|{A, B}) ? 8'h01 : 8'h00;
      3'b100: ALUout = (&{A, B}) ? 8'h01 : 8'h00;
      3'b101: ALUout = {A, B};
      default: ALUout = 8'h00;
    endcase
  end

  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (Valid) begin
      vld_cnt    = vld_cnt + 1;
      res_at_vld = Result;
      vld_cyc    = cyc;
    end
    if (State == 2'b10 && prev_state != 2'b10) exec_cyc = cyc;
    if (State == 2'b01) saw_wait_b = 1'b1;
    prev_state = State;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    if (obs !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] f, input logic a, input int hold);
    @(negedge Clock);
    Data = d; Func = f; Acc = a; Go = 1'b1;
    repeat (hold) @(negedge Clock);
    Go = 1'b0;
    repeat (6) @(negedge Clock);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (State != 2'b00 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_idle_timeout"}, {30'd0, State}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"},  {30'd0, State},    32'd0);
    check({tag, "_A"},      {28'd0, A},        32'd0);
    check({tag, "_B"},      {28'd0, B},        32'd0);
    check({tag, "_func"},   {29'd0, Function}, 32'd0);
    check({tag, "_result"}, {24'd0, Result},   32'd0);
    check({tag, "_valid"},  {31'd0, Valid},    32'd0);
    check({tag, "_busy"},   {31'd0, Busy},     32'd0);
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #2 Reset_b = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(negedge Clock);
    Reset_b = 1'b1;
    repeat (2) @(negedge Clock);

    // add 3 + 5
    vld_cnt = 0;
    press(4'd3, 3'b000, 1'b0, 6);
    check("add_wait_state", {30'd0, State}, 32'd1);
    check("add_A", {28'd0, A}, 32'd3);
    check("add_busy", {31'd0, Busy}, 32'd1);
    check("add_vld_early", vld_cnt, 0);
    press(4'd5, 3'b000, 1'b0, 6);
    wait_idle("add");
    check("add_vld_cnt", vld_cnt, 1);
    check("add_result", {24'd0, Result}, 32'h08);
    check("add_res_at_vld", {24'd0, res_at_vld}, 32'h08);
    check("add_B", {28'd0, B}, 32'd5);
    check("add_latency", vld_cyc - exec_cyc, 2);
    check("add_busy_after", {31'd0, Busy}, 32'd0);

    // concat, with Func changed while waiting for B
    vld_cnt = 0;
    press(4'hA, 3'b101, 1'b0, 6);
    press(4'h5, 3'b000, 1'b0, 6);
    wait_idle("cat");
    check("cat_result", {24'd0, Result}, 32'hA5);
    check("cat_func", {29'd0, Function}, 32'd5);
    check("cat_vld_cnt", vld_cnt, 1);

    // accumulate from Result=8'h08
    press(4'd3, 3'b000, 1'b0, 6);
    press(4'd5, 3'b000, 1'b0, 6);
    wait_idle("acc_prep");
    check("acc_prep_result", {24'd0, Result}, 32'h08);
    vld_cnt = 0;
    saw_wait_b = 1'b0;
    press(4'd2, 3'b001, 1'b1, 6);
    wait_idle("acc");
    check("acc_no_wait_b", {31'd0, saw_wait_b}, 32'd0);
    check("acc_B", {28'd0, B}, 32'd8);
    check("acc_A", {28'd0, A}, 32'd2);
    check("acc_result", {24'd0, Result}, 32'h0A);
    check("acc_vld_cnt", vld_cnt, 1);
    Acc = 1'b0;

    // Go held high for 30 cycles in IDLE
    vld_cnt = 0;
    press(4'd7, 3'b011, 1'b0, 30);
    check("held_state", {30'd0, State}, 32'd1);
    check("held_A", {28'd0, A}, 32'd7);
    check("held_func", {29'd0, Function}, 32'd3);
    check("held_vld_cnt", vld_cnt, 0);

    // abort from WAIT_B with reset asserted between clock edges
    @(posedge Clock);
    #3 Reset_b = 1'b0;
    #1 check_zero("abort");
    @(negedge Clock);
    Reset_b = 1'b1;
    repeat (6) @(negedge Clock);
    check("abort_vld_cnt", vld_cnt, 0);
    check("abort_state_after", {30'd0, State}, 32'd0);

    // accumulate straight after reset: B taken from Result=0
    vld_cnt = 0;
    press(4'd4, 3'b001, 1'b1, 6);
    wait_idle("acc0");
    check("acc0_B", {28'd0, B}, 32'd0);
    check("acc0_result", {24'd0, Result}, 32'h04);
    Acc = 1'b0;

    // second Go edge lands while the operation is executing and is dropped
    press(4'd1, 3'b001, 1'b0, 6);
    check("drop_wait_state", {30'd0, State}, 32'd1);
    vld_cnt = 0;
    @(negedge Clock);
    Data = 4'd6; Go = 1'b1;
    @(negedge Clock);
    Go = 1'b0;
    @(negedge Clock);
    Go = 1'b1;
    repeat (6) @(negedge Clock);
    Go = 1'b0;
    repeat (8) @(negedge Clock);
    check("drop_vld_cnt", vld_cnt, 1);
    check("drop_result", {24'd0, Result}, 32'h07);
    check("drop_state", {30'd0, State}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
